mem_word_arbiter: RTL and testbench

Arbitrates the core's 32-bit instruction-fetch and data-access ports onto the single 64-bit physical-memory port. Sits directly below the `ooo` core inside `mp4`, replacing the direct instruction/data memory hookup once the 64-bit `pmem` interface is in use. Word reads select one half of a 64-bit beat. Masked word writes are done as read-modify-write, because `pmem` has no byte enables.

---
 rtl/mem_word_arbiter_if.sv | 42 ++++
 rtl/mem_word_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_word_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_word_arbiter_if.sv
// Bus bundle between the core's word ports, the arbiter and the 64-bit pmem port.
// slave  : the arbiter's view (serves the core's word requests, drives pmem).
// master : the environment's view (core requesters plus physical memory).
interface mem_word_arbiter_if;
   logic        instr_read;
   logic [31:0] instr_mem_address;
   logic        instr_mem_resp;
   logic [31:0] instr_mem_rdata;

   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_mem_address;
   logic [31:0] data_mem_wdata;
   logic        data_mem_resp;
   logic [31:0] data_mem_rdata;

   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   logic [63:0] pmem_wdata;
   logic        pmem_resp;
   logic [63:0] pmem_rdata;

   modport slave (
      input  instr_read, instr_mem_address,
      output instr_mem_resp, instr_mem_rdata,
      input  data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
      output data_mem_resp, data_mem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata
   );

   modport master (
      output instr_read, instr_mem_address,
      input  instr_mem_resp, instr_mem_rdata,
      output data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
      input  data_mem_resp, data_mem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata
   );
endinterface

// File: rtl/mem_word_arbiter.sv
// Round-robin arbiter putting the 32-bit instruction and data ports onto one
// 64-bit pmem port. Reads pick a half of the beat; masked writes are done as
// read-modify-write because pmem has no byte enables.
module mem_word_arbiter (
   input  logic              clk,
   input  logic              rst,
   mem_word_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, I_RD, D_RD, D_RMW_RD, D_RMW_WR, I_DONE, D_DONE
   } state_t;

   state_t      state, state_nx;
   logic        last;           // 0: instr granted last, 1: data granted last
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  mbe_q;
   logic [31:0] instr_rdata_q;
   logic [31:0] data_rdata_q;
   logic [63:0] beat_q;         // merged beat written back in D_RMW_WR

   logic        data_req;
   logic        gnt_i;
   logic        gnt_d;
   logic [31:0] rd_word;
   logic [63:0] merged;

   // A read+write request is a write; the op type lives in the state chosen at grant.
   assign data_req = bus.data_read | bus.data_write;
   assign rd_word  = addr_q[2] ? bus.pmem_rdata[63:32] : bus.pmem_rdata[31:0];

   // Grant only from IDLE; on a tie the side not served last wins.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (state == IDLE) begin
         if (bus.instr_read && (!data_req || last))
            gnt_i = 1'b1;
         else if (data_req)
            gnt_d = 1'b1;
      end
   end

   // Overlay the masked write bytes onto the half of the beat the word lives in.
   always_comb begin
      merged = bus.pmem_rdata;
      for (int b = 0; b < 8; b++) begin
         if ((b[2] == addr_q[2]) && mbe_q[b[1:0]])
            merged[b*8 +: 8] = wdata_q[b[1:0]*8 +: 8];
      end
   end

   // Next-state logic; DONE states always fall back to IDLE without granting.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (gnt_i)
               state_nx = I_RD;
            else if (gnt_d) begin
               if (!bus.data_write)
                  state_nx = D_RD;
               else if (bus.data_mbe == 4'h0)
                  state_nx = D_DONE;
               else
                  state_nx = D_RMW_RD;
            end
         end
         I_RD:     if (bus.pmem_resp) state_nx = I_DONE;
         D_RD:     if (bus.pmem_resp) state_nx = D_DONE;
         D_RMW_RD: if (bus.pmem_resp) state_nx = D_RMW_WR;
         D_RMW_WR: if (bus.pmem_resp) state_nx = D_DONE;
         I_DONE:   state_nx = IDLE;
         D_DONE:   state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Request latching, round-robin pointer and read/merge capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last          <= 1'b1;
         addr_q        <= '0;
         wdata_q       <= '0;
         mbe_q         <= '0;
         instr_rdata_q <= '0;
         data_rdata_q  <= '0;
         beat_q        <= '0;
      end else begin
         if (gnt_i) begin
            addr_q <= bus.instr_mem_address;
            last   <= 1'b0;
         end
         if (gnt_d) begin
            addr_q  <= bus.data_mem_address;
            wdata_q <= bus.data_mem_wdata;
            mbe_q   <= bus.data_mbe;
            last    <= 1'b1;
         end
         if (bus.pmem_resp) begin
            case (state)
               I_RD:     instr_rdata_q <= rd_word;
               D_RD:     data_rdata_q  <= rd_word;
               D_RMW_RD: beat_q        <= merged;
               default:  ;
            endcase
         end
      end
   end

   // All bus strobes and responses decode straight from state.
   assign bus.pmem_read       = (state == I_RD) || (state == D_RD) || (state == D_RMW_RD);
   assign bus.pmem_write      = (state == D_RMW_WR);
   assign bus.pmem_address    = {addr_q[31:3], 3'b000};
   assign bus.pmem_wdata      = beat_q;
   assign bus.instr_mem_resp  = (state == I_DONE);
   assign bus.data_mem_resp   = (state == D_DONE);
   assign bus.instr_mem_rdata = instr_rdata_q;
   assign bus.data_mem_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Bench for mem_word_arbiter: directed cycle-exact steps, then a randomized
// phase with both requesters always busy, checked against a byte-level memory.
module tb_mem_word_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mem_word_arbiter_if bif();
   mem_word_arbiter dut (.clk(clk), .rst(rst), .bus(bif.slave));

   always #5 clk = ~clk;

   // pmem response source: manual (directed) or automatic (random phase)
   bit          pm_auto = 1'b0;
   logic        man_resp, auto_resp;
   logic [63:0] man_rdata, auto_rdata;
   int          pm_cnt = 0;
   int          pm_lat = 0;
   assign bif.pmem_resp  = pm_auto ? auto_resp  : man_resp;
   assign bif.pmem_rdata = pm_auto ? auto_rdata : man_rdata;

   logic [63:0] pm_mem  [logic [31:0]];   // physical memory by beat address
   logic [7:0]  ref_mem [logic [31:0]];   // reference view by byte address

   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_mbe;
   logic        d_wr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   function automatic logic [31:0] rnd_addr();
      return 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++)
         w[i*8 +: 8] = ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : 8'h00;
      return w;
   endfunction

   task automatic new_data();
      int op;
      op      = int'($urandom_range(0, 3));
      d_addr  = rnd_addr();
      d_wdata = $urandom();
      d_mbe   = 4'($urandom_range(0, 15));
      d_wr    = (op != 0);
      bif.data_read        = (op == 0) || (op == 2);
      bif.data_write       = d_wr;
      bif.data_mem_address = d_addr;
      bif.data_mem_wdata   = d_wdata;
      bif.data_mbe         = d_mbe;
   endtask

   // Physical memory with random 0..3 cycle latency, used in the random phase.
   initial begin
      auto_resp  = 1'b0;
      auto_rdata = '0;
      forever begin
         @(negedge clk);
         auto_resp = 1'b0;
         if (pm_auto && rst && (bif.pmem_read || bif.pmem_write)) begin
            if (pm_cnt >= pm_lat) begin
               auto_resp = 1'b1;
               if (bif.pmem_read)
                  auto_rdata = pm_mem.exists(bif.pmem_address) ? pm_mem[bif.pmem_address] : 64'h0;
               else
                  pm_mem[bif.pmem_address] = bif.pmem_wdata;
               pm_cnt = 0;
               pm_lat = int'($urandom_range(0, 3));
            end else
               pm_cnt++;
         end else
            pm_cnt = 0;
      end
   end

   initial begin
      logic [31:0] i_addr;
      bit          exp_instr, prev_ir, prev_dr;
      int          n_i, n_d, guard;

      rst = 1'b0;
      bif.instr_read = 1'b1;  bif.instr_mem_address = 32'h0000_0064;
      bif.data_read = 1'b0;   bif.data_write = 1'b0;  bif.data_mbe = 4'h0;
      bif.data_mem_address = '0; bif.data_mem_wdata = '0;
      man_resp = 1'b0; man_rdata = '0;

      // reset held two edges with a fetch pending
      nxt; nxt;
      chk("rst_pmem_read",  64'(bif.pmem_read),       64'h0);
      chk("rst_pmem_write", 64'(bif.pmem_write),      64'h0);
      chk("rst_i_resp",     64'(bif.instr_mem_resp),  64'h0);
      chk("rst_d_resp",     64'(bif.data_mem_resp),   64'h0);
      chk("rst_i_rdata",    64'(bif.instr_mem_rdata), 64'h0);
      chk("rst_wdata",      bif.pmem_wdata,           64'h0);
      rst = 1'b1;

      // fetch at 0x64: upper half of beat
      nxt;
      chk("i_pmem_read", 64'(bif.pmem_read),    64'h1);
      chk("i_pmem_addr", 64'(bif.pmem_address), 64'h60);
      chk("i_no_write",  64'(bif.pmem_write),   64'h0);
      man_resp = 1'b1; man_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      nxt;
      man_resp = 1'b0;
      chk("i_resp",      64'(bif.instr_mem_resp),  64'h1);
      chk("i_rdata",     64'(bif.instr_mem_rdata), 64'hAAAA_BBBB);
      chk("i_read_drop", 64'(bif.pmem_read),       64'h0);
      bif.instr_read = 1'b0;
      nxt;
      chk("i_resp_pulse", 64'(bif.instr_mem_resp), 64'h0);

      // RMW: 0x1000, mbe 0110, beat all ones
      bif.data_write = 1'b1; bif.data_mem_address = 32'h1000;
      bif.data_mbe = 4'b0110; bif.data_mem_wdata = 32'h1122_3344;
      nxt;
      chk("rmw1_read", 64'(bif.pmem_read),    64'h1);
      chk("rmw1_addr", 64'(bif.pmem_address), 64'h1000);
      man_resp = 1'b1; man_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      nxt;
      chk("rmw1_write",   64'(bif.pmem_write), 64'h1);
      chk("rmw1_no_read", 64'(bif.pmem_read),  64'h0);
      chk("rmw1_wdata",   bif.pmem_wdata,      64'hFFFF_FFFF_FF22_33FF);
      nxt;
      man_resp = 1'b0;
      chk("rmw1_resp",     64'(bif.data_mem_resp), 64'h1);
      chk("rmw1_wr_drop",  64'(bif.pmem_write),    64'h0);
      bif.data_write = 1'b0;
      nxt;
      chk("rmw1_resp_pulse", 64'(bif.data_mem_resp), 64'h0);

      // RMW: 0x1004 full mask, slow pmem
      bif.data_write = 1'b1; bif.data_mem_address = 32'h1004;
      bif.data_mbe = 4'hF; bif.data_mem_wdata = 32'hDEAD_BEEF;
      nxt; nxt;
      chk("rmw2_read_hold", 64'(bif.pmem_read), 64'h1);
      man_resp = 1'b1; man_rdata = 64'h0;
      nxt;
      man_resp = 1'b0;
      chk("rmw2_wdata", bif.pmem_wdata, 64'hDEAD_BEEF_0000_0000);
      nxt;
      chk("rmw2_write_hold", 64'(bif.pmem_write),    64'h1);
      chk("rmw2_no_resp",    64'(bif.data_mem_resp), 64'h0);
      man_resp = 1'b1;
      nxt;
      man_resp = 1'b0;
      chk("rmw2_resp", 64'(bif.data_mem_resp), 64'h1);
      bif.data_write = 1'b0;
      nxt;

      // zero-mask write completes without pmem traffic
      bif.data_write = 1'b1; bif.data_mem_address = 32'h1008; bif.data_mbe = 4'h0;
      nxt;
      chk("mbe0_resp",  64'(bif.data_mem_resp),            64'h1);
      chk("mbe0_quiet", 64'(bif.pmem_read | bif.pmem_write), 64'h0);
      bif.data_write = 1'b0;
      nxt;

      // data read of the lower half
      bif.data_read = 1'b1; bif.data_mem_address = 32'h2000;
      nxt;
      chk("drd_addr", 64'(bif.pmem_address), 64'h2000);
      man_resp = 1'b1; man_rdata = 64'h0123_4567_89AB_CDEF;
      nxt;
      man_resp = 1'b0;
      chk("drd_resp",  64'(bif.data_mem_resp),  64'h1);
      chk("drd_rdata", 64'(bif.data_mem_rdata), 64'h89AB_CDEF);
      bif.data_read = 1'b0;
      nxt;

      // read+write together acts as a write; upper-half byte 0
      bif.data_read = 1'b1; bif.data_write = 1'b1; bif.data_mem_address = 32'h3004;
      bif.data_mbe = 4'b0001; bif.data_mem_wdata = 32'h0000_00A5;
      nxt;
      man_resp = 1'b1; man_rdata = 64'h1111_1111_2222_2222;
      nxt;
      chk("rw_is_write", 64'(bif.pmem_write), 64'h1);
      chk("rw_wdata",    bif.pmem_wdata,      64'h1111_11A5_2222_2222);
      nxt;
      man_resp = 1'b0;
      bif.data_read = 1'b0; bif.data_write = 1'b0;
      nxt;

      // reset during D_RMW_WR abandons the write; late pmem_resp ignored
      bif.data_write = 1'b1; bif.data_mem_address = 32'h4000;
      bif.data_mbe = 4'hF; bif.data_mem_wdata = 32'h1234_5678;
      nxt;
      man_resp = 1'b1; man_rdata = 64'h0;
      nxt;
      man_resp = 1'b0;
      chk("abort_in_write", 64'(bif.pmem_write), 64'h1);
      rst = 1'b0;
      nxt;
      chk("abort_wr_drop", 64'(bif.pmem_write),    64'h0);
      chk("abort_no_resp", 64'(bif.data_mem_resp), 64'h0);
      bif.data_write = 1'b0; rst = 1'b1;
      nxt;
      man_resp = 1'b1;
      nxt;
      man_resp = 1'b0;
      chk("late_resp_quiet", 64'({bif.pmem_read, bif.pmem_write, bif.instr_mem_resp, bif.data_mem_resp}), 64'h0);
      nxt;
      chk("late_resp_quiet2", 64'({bif.pmem_read, bif.pmem_write, bif.instr_mem_resp, bif.data_mem_resp}), 64'h0);

      // random phase: both requesters always busy, grants must alternate
      rst = 1'b0;
      nxt;
      rst = 1'b1;
      pm_mem.delete();
      ref_mem.delete();
      pm_auto = 1'b1;
      i_addr = rnd_addr();
      bif.instr_read = 1'b1; bif.instr_mem_address = i_addr;
      new_data();
      exp_instr = 1'b1; prev_ir = 1'b0; prev_dr = 1'b0;
      n_i = 0; n_d = 0; guard = 0;
      while ((n_i < 30 || n_d < 30) && guard < 4000) begin
         nxt;
         guard++;
         chk("no_overlap", 64'(bif.pmem_read & bif.pmem_write), 64'h0);
         chk("beat_align", 64'(bif.pmem_address[2:0]), 64'h0);
         if (bif.instr_mem_resp && bif.data_mem_resp)
            chk("dual_resp", 64'h1, 64'h0);
         if (bif.instr_mem_resp) begin
            chk("i_one_cycle",  64'(prev_ir),              64'h0);
            chk("rr_instr",     64'(exp_instr),            64'h1);
            chk("rand_i_rdata", 64'(bif.instr_mem_rdata),  64'(ref_word(i_addr)));
            exp_instr = 1'b0;
            n_i++;
            i_addr = rnd_addr();
            bif.instr_mem_address = i_addr;
         end
         if (bif.data_mem_resp) begin
            chk("d_one_cycle", 64'(prev_dr),   64'h0);
            chk("rr_data",     64'(exp_instr), 64'h0);
            if (d_wr) begin
               for (int i = 0; i < 4; i++)
                  if (d_mbe[i]) ref_mem[d_addr + 32'(i)] = d_wdata[i*8 +: 8];
            end else
               chk("rand_d_rdata", 64'(bif.data_mem_rdata), 64'(ref_word(d_addr)));
            exp_instr = 1'b1;
            n_d++;
            new_data();
         end
         prev_ir = bif.instr_mem_resp;
         prev_dr = bif.data_mem_resp;
      end
      chk("rand_progress", 64'(guard < 4000), 64'h1);

      bif.instr_read = 1'b0; bif.data_read = 1'b0; bif.data_write = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
